cv32e40p_ex_alu_voter: RTL and testbench

Fault-tolerant EX-stage result voter and replica manager for the replicated ALU datapath. It majority-votes the results of four ALU replicas, of which at most three are active at a time, and keeps a saturating error counter per replica. Replicas whose counter reaches the threshold are retired, and the block drives `sel_mux_ex` and `clock_enable_alu`, which the ID/EX pipeline register forwards to EX. It is the consumer/controller end of that ID/EX fault-tolerance interface.

---
 rtl/cv32e40p_ex_alu_voter.sv | 213 +++++++++++++++++++++
 tb/tb_cv32e40p_ex_alu_voter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_ex_alu_voter.sv
// EX-stage majority voter and replica manager for the replicated ALU.
// Votes up to three active replicas, tracks a saturating error counter
// per replica, retires replicas that reach the threshold and drives the
// active-set encoding and clock enables back to the ID/EX register.
module cv32e40p_ex_alu_voter #(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned CNT_W        = 4,
   parameter int unsigned ERR_THRESH   = 8,
   parameter int unsigned DECAY_PERIOD = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  vote_en_i,
   input  logic [3:0][DATA_W-1:0] res_i,
   input  logic [3:0]            cmp_i,
   input  logic                  clear_i,
   output logic [DATA_W-1:0]     result_o,
   output logic                  cmp_o,
   output logic                  vote_err_o,
   output logic [2:0]            sel_mux_ex_o,
   output logic [3:0]            clock_enable_alu_o,
   output logic [3:0]            faulty_o,
   output logic [3:0][CNT_W-1:0] err_cnt_o
);

   localparam int unsigned      DEC_W      = $clog2(DECAY_PERIOD + 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] THRESH     = CNT_W'(ERR_THRESH);
   localparam logic [DEC_W-1:0] DECAY_LAST = DEC_W'(DECAY_PERIOD - 1);

   typedef enum logic [1:0] {
      MODE_TMR,
      MODE_DMR,
      MODE_SIMPLEX,
      MODE_FAIL
   } mode_e;

   // A vote unit is the result word together with its comparison flag.
   typedef logic [DATA_W:0] unit_t;

   // Lowest-indexed up-to-three healthy replicas; with all four healthy
   // replica 3 is the spare.
   function automatic logic [3:0] active_of(input logic [3:0] healthy);
      return (&healthy) ? 4'b0111 : healthy;
   endfunction

   // Active-set encoding forwarded to the ID/EX register.
   function automatic logic [2:0] sel_of(input logic [3:0] healthy);
      unique case (healthy)
         4'b1111, 4'b0111:                   return 3'b000;
         4'b1011:                            return 3'b001;
         4'b1101:                            return 3'b010;
         4'b1110:                            return 3'b011;
         4'b0011, 4'b0101, 4'b0110,
         4'b1001, 4'b1010, 4'b1100:          return 3'b100;
         4'b0001, 4'b0010, 4'b0100, 4'b1000: return 3'b101;
         default:                            return 3'b111;
      endcase
   endfunction

   // Registered state
   logic [3:0]            faulty_q, faulty_d;
   logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [DEC_W-1:0]      decay_q, decay_d;
   logic [2:0]            sel_q, sel_d;
   logic [3:0]            ce_q, ce_d;

   // Vote datapath
   mode_e           mode;
   unit_t [3:0]     unit;
   unit_t [2:0]     u;
   logic  [2:0][1:0] idx;
   unit_t           voted;
   logic            err;
   logic            unanimous;
   logic [3:0]      inc;

   // Decode the operating mode from the registered active-set encoding.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      mode = MODE_FAIL;
      if (!sel_q[2]) begin
         mode = MODE_TMR;
      end else begin
         unique case (sel_q[1:0])
            2'b00:   mode = MODE_DMR;
            2'b01:   mode = MODE_SIMPLEX;
            default: mode = MODE_FAIL;
         endcase
      end
   end

   // Gather the active replicas' vote units in index order.
   always_comb begin
      int slot;
      // NOTE: combinational blocks use blocking '=' so later statements
      // see the value just computed (slot advances within one pass).
      slot = 0;
      unit = '0;
      u    = '0;
      idx  = '0;
      for (int r = 0; r < 4; r++) begin
         unit[r] = {res_i[r], cmp_i[r]};
         if (ce_q[r] && slot < 3) begin
            u[slot]   = unit[r];
            idx[slot] = 2'(r);
            slot      = slot + 1;
         end
      end
   end

   // Majority vote over the active set and minority detection.
   always_comb begin
      voted     = u[0];
      err       = 1'b0;
      unanimous = 1'b0;
      inc       = '0;
      unique case (mode)
         MODE_TMR: begin
            if (u[0] == u[1]) begin
               if (u[2] == u[0]) unanimous = 1'b1;
               else              inc[idx[2]] = 1'b1;
            end else if (u[0] == u[2]) begin
               inc[idx[1]] = 1'b1;
            end else if (u[1] == u[2]) begin
               voted       = u[1];
               inc[idx[0]] = 1'b1;
            end else begin
               err = 1'b1;
            end
         end
         MODE_DMR: begin
            if (u[0] == u[1]) begin
               unanimous = 1'b1;
            end else begin
               err         = 1'b1;
               inc[idx[0]] = 1'b1;
               inc[idx[1]] = 1'b1;
            end
         end
         MODE_SIMPLEX: begin
            unanimous = 1'b1;
         end
         default: begin
            voted = '0;
            err   = 1'b1;
         end
      endcase
   end

   assign result_o   = voted[DATA_W:1];
   assign cmp_o      = voted[0];
   assign vote_err_o = err & vote_en_i;

   // Next-state for fault mask, error counters and decay counter.
   always_comb begin
      faulty_d = faulty_q;
      cnt_d    = cnt_q;
      decay_d  = decay_q;
      if (clear_i) begin
         faulty_d = '0;
         cnt_d    = '0;
         decay_d  = '0;
      end else if (vote_en_i) begin
         if (unanimous) begin
            if (decay_q == DECAY_LAST) begin
               decay_d = '0;
               for (int r = 0; r < 4; r++) begin
                  if (!faulty_q[r] && cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - 1'b1;
               end
            end else begin
               decay_d = decay_q + 1'b1;
            end
         end else begin
            decay_d = '0;
            for (int r = 0; r < 4; r++) begin
               if (inc[r]) begin
                  if (cnt_q[r] != CNT_MAX) cnt_d[r] = cnt_q[r] + 1'b1;
                  if (cnt_d[r] >= THRESH)  faulty_d[r] = 1'b1;
               end
            end
         end
      end
      sel_d = sel_of(~faulty_d);
      ce_d  = active_of(~faulty_d);
   end

   // State register; the active-set outputs are registered alongside the mask.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         faulty_q <= '0;
         cnt_q    <= '0;
         decay_q  <= '0;
         sel_q    <= 3'b000;
         ce_q     <= 4'b0111;
      end else begin
         // NOTE: sequential state uses non-blocking '<=' so every flop
         // samples pre-edge values regardless of statement order.
         faulty_q <= faulty_d;
         cnt_q    <= cnt_d;
         decay_q  <= decay_d;
         sel_q    <= sel_d;
         ce_q     <= ce_d;
      end
   end

   assign faulty_o           = faulty_q;
   assign err_cnt_o          = cnt_q;
   assign sel_mux_ex_o       = sel_q;
   assign clock_enable_alu_o = ce_q;

endmodule

// File: tb/tb_cv32e40p_ex_alu_voter.sv
// Scoreboard bench for cv32e40p_ex_alu_voter: a driver applies directed
// and random votes, a behavioural model pushes the expected response,
// and a monitor pops and compares it each cycle.
module tb_cv32e40p_ex_alu_voter;

   localparam int DW     = 32;
   localparam int THR    = 8;
   localparam int CMAX   = 15;
   localparam int DECAY  = 16;

   typedef struct packed {
      logic [DW-1:0]   res;
      logic            cmp;
      logic            err;
      logic [2:0]      sel;
      logic [3:0]      ce;
      logic [3:0]      faulty;
      logic [3:0][3:0] cnt;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               vote_en_i = 1'b0;
   logic [3:0][DW-1:0] res_i = '0;
   logic [3:0]         cmp_i = '0;
   logic               clear_i = 1'b0;
   logic [DW-1:0]      result_o;
   logic               cmp_o;
   logic               vote_err_o;
   logic [2:0]         sel_mux_ex_o;
   logic [3:0]         clock_enable_alu_o;
   logic [3:0]         faulty_o;
   logic [3:0][3:0]    err_cnt_o;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];

   // Reference model state
   bit [3:0] m_faulty;
   int       m_cnt[4];
   int       m_decay;

   cv32e40p_ex_alu_voter dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .vote_en_i          (vote_en_i),
      .res_i              (res_i),
      .cmp_i              (cmp_i),
      .clear_i            (clear_i),
      .result_o           (result_o),
      .cmp_o              (cmp_o),
      .vote_err_o         (vote_err_o),
      .sel_mux_ex_o       (sel_mux_ex_o),
      .clock_enable_alu_o (clock_enable_alu_o),
      .faulty_o           (faulty_o),
      .err_cnt_o          (err_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_faulty = '0;
      foreach (m_cnt[r]) m_cnt[r] = 0;
      m_decay = 0;
   endtask

   // Evaluate the current inputs against the model, push the expected
   // response, then advance the model to the post-edge state.
   task automatic model_step();
      exp_t          e;
      int            act[$];
      int            hc;
      logic [DW:0]   uu[4];
      int            best;
      int            bi;
      int            n;
      bit            unan;
      bit            err;
      bit            inc[4];
      hc   = 0;
      best = 0;
      bi   = 0;
      unan = 0;
      err  = 0;
      e    = '0;
      for (int r = 0; r < 4; r++) begin
         inc[r] = 0;
         uu[r]  = {res_i[r], cmp_i[r]};
         e.cnt[r] = 4'(m_cnt[r]);
         if (!m_faulty[r]) begin
            hc++;
            if (act.size() < 3) act.push_back(r);
         end
      end
      e.faulty = m_faulty;
      foreach (act[i]) e.ce[act[i]] = 1'b1;
      case (hc)
         4: e.sel = 3'b000;
         3: for (int r = 0; r < 4; r++) if (m_faulty[r]) e.sel = 3'(3 - r);
         2: e.sel = 3'b100;
         1: e.sel = 3'b101;
         default: e.sel = 3'b111;
      endcase
      if (act.size() == 0) begin
         err = 1;
      end else begin
         foreach (act[i]) begin
            n = 0;
            foreach (act[j]) if (uu[act[j]] == uu[act[i]]) n++;
            if (n > best) begin
               best = n;
               bi   = act[i];
            end
         end
         if (best == act.size()) begin
            unan = 1;
            {e.res, e.cmp} = uu[bi];
         end else if (best >= 2) begin
            {e.res, e.cmp} = uu[bi];
            foreach (act[i]) if (uu[act[i]] != uu[bi]) inc[act[i]] = 1;
         end else begin
            err = 1;
            {e.res, e.cmp} = uu[act[0]];
            if (act.size() == 2) foreach (act[i]) inc[act[i]] = 1;
         end
      end
      e.err = err & vote_en_i;
      sb.push_back(e);

      if (clear_i) begin
         model_reset();
      end else if (vote_en_i) begin
         if (unan) begin
            m_decay++;
            if (m_decay == DECAY) begin
               m_decay = 0;
               for (int r = 0; r < 4; r++) if (!m_faulty[r] && m_cnt[r] > 0) m_cnt[r]--;
            end
         end else begin
            m_decay = 0;
            for (int r = 0; r < 4; r++) begin
               if (inc[r]) begin
                  if (m_cnt[r] < CMAX) m_cnt[r]++;
                  if (m_cnt[r] >= THR) m_faulty[r] = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic drive(input logic en, input logic clr,
                        input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                        input logic [DW-1:0] r2, input logic [DW-1:0] r3,
                        input logic [3:0] c);
      @(posedge clk);
      #1;
      vote_en_i = en;
      clear_i   = clr;
      res_i[0]  = r0;
      res_i[1]  = r1;
      res_i[2]  = r2;
      res_i[3]  = r3;
      cmp_i     = c;
      model_step();
   endtask

   // Monitor: compare the DUT against the oldest expected response.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && sb.size() > 0) begin
            e = sb.pop_front();
            check("result",   64'(result_o),           64'(e.res));
            check("cmp",      64'(cmp_o),              64'(e.cmp));
            check("vote_err", 64'(vote_err_o),         64'(e.err));
            check("sel",      64'(sel_mux_ex_o),       64'(e.sel));
            check("clk_en",   64'(clock_enable_alu_o), 64'(e.ce));
            check("faulty",   64'(faulty_o),           64'(e.faulty));
            check("err_cnt",  64'(err_cnt_o),          64'(e.cnt));
         end
      end
   end

   // Driver: directed scenarios, random traffic, then FAIL and async reset.
   initial begin
      logic [DW-1:0] base;
      logic [DW-1:0] v[4];
      logic [3:0]    c;
      logic          cb;
      int            budget;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_sel",    64'(sel_mux_ex_o),       64'h0);
      check("rst_clk_en", 64'(clock_enable_alu_o), 64'h7);
      check("rst_faulty", 64'(faulty_o),           64'h0);
      check("rst_cnt",    64'(err_cnt_o),          64'h0);

      // Retire replica 0; replica 3 takes over.
      repeat (8) drive(1, 0, 7, 5, 5, $urandom, 4'h0);

      // Decay: push cnt[1] to 3, then a broken and a full decay period.
      repeat (3) drive(1, 0, $urandom, 9, 5, 5, 4'h0);
      repeat (9) drive(1, 0, $urandom, 5, 5, 5, 4'h0);
      drive(1, 0, $urandom, 5, 6, 5, 4'h0);
      repeat (16) drive(1, 0, $urandom, 5, 5, 5, 4'h0);

      // No majority on {1,2,3}.
      drive(1, 0, $urandom, 1, 2, 3, 4'h0);
      // Same results, differing comparison flag on replica 3.
      drive(1, 0, $urandom, 4, 4, 4, 4'b0111);

      // Retire replica 1 to enter DMR on {2,3}.
      while (m_faulty[1] == 1'b0) drive(1, 0, $urandom, 9, 5, 5, 4'h0);
      drive(1, 0, $urandom, $urandom, 11, 12, 4'h0);
      drive(1, 0, $urandom, $urandom, 13, 13, 4'h0);
      drive(0, 0, $urandom, $urandom, 20, 21, 4'h0);

      // Clear in the same cycle as a threshold-reaching vote.
      while (m_cnt[2] < THR - 1 && m_cnt[3] < THR - 1)
         drive(1, 0, $urandom, $urandom, 11, 12, 4'h0);
      drive(1, 1, $urandom, $urandom, 11, 12, 4'h0);
      drive(0, 0, 1, 1, 1, 1, 4'h0);

      // Random traffic with sparse corruption and occasional repair.
      for (int t = 0; t < 400; t++) begin
         base = $urandom;
         cb   = 1'($urandom);
         for (int r = 0; r < 4; r++) begin
            v[r] = base;
            c[r] = cb;
            if ($urandom_range(7) == 0) v[r] = $urandom_range(3);
            if ($urandom_range(15) == 0) c[r] = ~cb;
         end
         drive(($urandom_range(7) != 0), ($urandom_range(59) == 0),
               v[0], v[1], v[2], v[3], c);
      end

      // Walk down to FAIL from a clean state.
      drive(1, 1, 0, 0, 0, 0, 4'h0);
      while (m_faulty[0] == 1'b0) drive(1, 0, 1, 2, 2, 2, 4'h0);
      while (m_faulty[1] == 1'b0) drive(1, 0, 0, 1, 2, 2, 4'h0);
      while (m_faulty != 4'hF)    drive(1, 0, 0, 0, 3, 4, 4'h0);
      drive(1, 0, 5, 5, 5, 5, 4'hF);
      drive(0, 0, 5, 5, 5, 5, 4'hF);
      drive(1, 0, 6, 7, 8, 9, 4'h3);

      // Asynchronous reset in the middle of a cycle.
      drive(0, 0, 1, 1, 1, 1, 4'h0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_sel",    64'(sel_mux_ex_o),       64'h0);
      check("arst_clk_en", 64'(clock_enable_alu_o), 64'h7);
      check("arst_faulty", 64'(faulty_o),           64'h0);
      check("arst_cnt",    64'(err_cnt_o),          64'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 0, 3, 4, 4, 9, 4'h0);
      drive(1, 0, 3, 4, 4, 9, 4'h0);
      drive(0, 0, 0, 0, 0, 0, 4'h0);

      budget = 10;
      while (sb.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      check("drain", 64'(sb.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
